// File: rtl/bit_serializer_pkg.sv
// Shared widths and state encoding for the bit-length path (measurement and serializer).
// Keeping the widths here keeps both ends of the chain consistent.
package bit_serializer_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } ser_state_t;

endpackage

// File: rtl/bit_serializer_len_clamp.sv
// Combinational length clamp: len_out = min(len_in, DATA_W).
// Shared by the measurement and transmit sides of the bit-length path.
module len_clamp
    import bit_serializer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic [LEN_W-1:0] len_in,
    output logic [LEN_W-1:0] len_out
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

    always_comb begin
        len_out = (len_in > MAX_LEN) ? MAX_LEN : len_in;
    end

endmodule

// File: rtl/bit_serializer.sv
// MSB-first serializer for the significant bits of a number, one bit per clock,
// driven by the md_start/md_end four-phase handshake used by the measurement block.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              md_start,
    input  logic [DATA_W-1:0] num_in,
    input  logic [LEN_W-1:0]  len_in,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              md_end
);

    // Handshake: md_start is a level held for the whole job; md_end rises when the
    // last bit has been sent and falls on the first edge that samples md_start low.
    // Dropping md_start before md_end aborts the job and md_end is never raised.

    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic              bit_out_q, bit_out_d;
    logic              bit_valid_q, bit_valid_d;
    logic              busy_q, busy_d;
    logic              md_end_q, md_end_d;

    logic [LEN_W-1:0]  len_clamped;
    logic [LEN_W-1:0]  align_shift;

    len_clamp #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) u_len_clamp (
        .len_in  (len_in),
        .len_out (len_clamped)
    );

    // Left-align the significant field so the MSB is always at the top bit;
    // bits above L-1 fall off the end and are never transmitted.
    assign align_shift = LEN_W'(DATA_W) - len_clamped;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        cnt_d       = cnt_q;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        busy_d      = busy_q;
        md_end_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (md_start) begin
                    shreg_d = num_in << align_shift;
                    cnt_d   = len_clamped;
                    busy_d  = 1'b1;
                    state_d = (len_clamped != '0) ? ST_SHIFT : ST_DONE;
                end
            end

            ST_SHIFT: begin
                if (!md_start) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    shreg_d = '0;
                end else begin
                    bit_out_d   = shreg_q[DATA_W-1];
                    bit_valid_d = 1'b1;
                    shreg_d     = shreg_q << 1;
                    cnt_d       = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (md_start) begin
                    md_end_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
                shreg_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            md_end_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            md_end_q    <= md_end_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign busy      = busy_q;
    assign md_end    = md_end_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: a job table with hand-computed bit streams,
// plus hand-written abort, mid-job reset and held-md_start sequences.
module tb_bit_serializer;

    logic        clk;
    logic        rstn;
    logic        md_start;
    logic [63:0] num_in;
    logic [7:0]  len_in;
    logic        bit_out;
    logic        bit_valid;
    logic        busy;
    logic        md_end;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [63:0] num;
        logic [7:0]  len;
        int          exp_n;     // expected number of valid bits
        logic [63:0] exp_bits;  // expected stream, exp_bits[exp_n-1] sent first
    } job_vec_t;

    job_vec_t vecs[$];

    bit_serializer dut (
        .clk       (clk),
        .rstn      (rstn),
        .md_start  (md_start),
        .num_in    (num_in),
        .len_in    (len_in),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .md_end    (md_end)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic accept(input logic [63:0] num, input logic [7:0] len);
        @(negedge clk);
        num_in   = num;
        len_in   = len;
        md_start = 1'b1;
        step();
        check("accept_busy", 64'(busy), 1);
        check("accept_valid", 64'(bit_valid), 0);
        check("accept_md_end", 64'(md_end), 0);
        // later input changes must not affect the running job
        @(negedge clk);
        num_in = ~num;
        len_in = len + 8'd3;
    endtask

    task automatic expect_bits(input int n, input logic [63:0] bits);
        for (int k = 1; k <= n; k++) begin
            step();
            check("bit_valid", 64'(bit_valid), 1);
            check("bit_out", 64'(bit_out), 64'(bits[n-k]));
            check("md_end_during_shift", 64'(md_end), 0);
        end
    endtask

    task automatic finish_job(input int hold);
        step();
        check("md_end_rise", 64'(md_end), 1);
        check("done_valid", 64'(bit_valid), 0);
        check("done_bit_out", 64'(bit_out), 0);
        check("done_busy", 64'(busy), 1);
        for (int i = 0; i < hold; i++) begin
            step();
            check("md_end_hold", 64'(md_end), 1);
            check("no_second_job", 64'(bit_valid), 0);
        end
        @(negedge clk);
        md_start = 1'b0;
        step();
        check("release_md_end", 64'(md_end), 0);
        check("release_busy", 64'(busy), 0);
        step();
        check("idle_valid", 64'(bit_valid), 0);
        check("idle_state", 64'(dut.state_q), 0);
    endtask

    initial begin
        rstn     = 1'b0;
        md_start = 1'b0;
        num_in   = '0;
        len_in   = '0;

        vecs.push_back('{64'h9,                   8'd4,   4,  64'b1001});
        vecs.push_back('{64'hFF,                  8'd0,   0,  64'h0});
        vecs.push_back('{64'h8000_0000_0000_0001, 8'd200, 64, 64'h8000_0000_0000_0001});
        vecs.push_back('{64'hF0,                  8'd6,   6,  64'b110000});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFA5, 8'd8,   8,  64'hA5});
        vecs.push_back('{64'hDEAD_BEEF_0123_4567, 8'd64,  64, 64'hDEAD_BEEF_0123_4567});
        vecs.push_back('{64'h1,                   8'd65,  64, 64'h1});
        vecs.push_back('{64'hFFFE,                8'd1,   1,  64'h0});
        vecs.push_back('{64'h5,                   8'd3,   3,  64'b101});

        step();
        step();
        check("rst_bit_out", 64'(bit_out), 0);
        check("rst_valid", 64'(bit_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_md_end", 64'(md_end), 0);
        check("rst_state", 64'(dut.state_q), 0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        check("idle_busy", 64'(busy), 0);

        // table-driven jobs
        foreach (vecs[i]) begin
            accept(vecs[i].num, vecs[i].len);
            expect_bits(vecs[i].exp_n, vecs[i].exp_bits);
            finish_job(1);
        end

        // abort after 3 of 10 bits: 10'b10_1100_1110
        accept(64'h2CE, 8'd10);
        expect_bits(3, 64'b101);
        @(negedge clk);
        md_start = 1'b0;
        step();
        check("abort_valid", 64'(bit_valid), 0);
        check("abort_busy", 64'(busy), 0);
        check("abort_md_end", 64'(md_end), 0);
        check("abort_state", 64'(dut.state_q), 0);
        step();
        check("abort_md_end_later", 64'(md_end), 0);
        accept(64'h3, 8'd2);
        expect_bits(2, 64'b11);
        finish_job(0);

        // reset after bit 2 of 6: 6'b110101
        accept(64'h35, 8'd6);
        expect_bits(2, 64'b11);
        @(negedge clk);
        rstn = 1'b0;
        step();
        check("midrst_bit_out", 64'(bit_out), 0);
        check("midrst_valid", 64'(bit_valid), 0);
        check("midrst_busy", 64'(busy), 0);
        check("midrst_md_end", 64'(md_end), 0);
        check("midrst_state", 64'(dut.state_q), 0);
        @(negedge clk);
        rstn   = 1'b1;
        num_in = 64'h35;
        len_in = 8'd6;
        step();
        check("reaccept_busy", 64'(busy), 1);
        check("reaccept_valid", 64'(bit_valid), 0);
        expect_bits(6, 64'b110101);
        finish_job(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
